// File: rtl/gray_matrix_3x3.sv
// gray_matrix_3x3
// Builds a 3x3 sliding window over an 8-bit grayscale pixel stream. Two line
// buffers hold the previous line and the line before that. The hsync, vsync
// and de strobes are delayed so that they line up with the window output.
//
// Ports
//   clk           pixel clock; all logic runs on its rising edge
//   rst           synchronous, active-high reset
//   gray_hsync    line sync from the gray stage
//   gray_vsync    frame sync from the gray stage (a rising edge starts a frame)
//   gray_de       input pixel valid
//   gray_data     input pixel, DW bits
//   matrix_hsync  gray_hsync delayed by 2 cycles
//   matrix_vsync  gray_vsync delayed by 2 cycles
//   matrix_de     window valid
//   matrix_data   window {p11,p12,p13,p21,p22,p23,p31,p32,p33}
//                 p11 is at the MSBs; p33 is the current pixel
module gray_matrix_3x3 #(
  parameter int IMG_WIDTH = 640,
  parameter int DW        = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            gray_hsync,
  input  logic            gray_vsync,
  input  logic [DW-1:0]   gray_data,
  input  logic            gray_de,
  output logic            matrix_hsync,
  output logic            matrix_vsync,
  output logic            matrix_de,
  output logic [9*DW-1:0] matrix_data
);

  localparam int CW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam logic [CW-1:0] COL_MAX = CW'(IMG_WIDTH - 1);

  logic [DW-1:0] lb1 [IMG_WIDTH];
  logic [DW-1:0] lb2 [IMG_WIDTH];

  logic [CW-1:0] col_cnt;
  logic          line_full;
  logic [1:0]    row_cnt;

  // Stage 1: input sample, line-buffer read and row masks.
  logic          hs_d1, vs_d1, de_d1;
  logic          valid_d1, first_d1, top_ok_d1, mid_ok_d1;
  logic [DW-1:0] data_d1, lb1_q, lb2_q;
  logic [CW-1:0] col_d1;

  // Stage 2: the two older taps of each row, newest tap in the low bits.
  logic [2*DW-1:0] sh_top, sh_mid, sh_bot;

  logic de_rise, de_fall, vs_rise, pix_ok;
  logic [DW-1:0]   top_cur, mid_cur;
  logic [2*DW-1:0] top_prev, mid_prev, bot_prev;

  assign de_rise = gray_de & ~de_d1;
  assign de_fall = ~gray_de & de_d1;
  assign vs_rise = gray_vsync & ~vs_d1;
  // Pixels past the end of an overlong line are dropped from the buffers and
  // from the window output.
  assign pix_ok  = gray_de & ~line_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      col_cnt   <= '0;
      line_full <= 1'b0;
      row_cnt   <= '0;
      hs_d1     <= 1'b0;
      vs_d1     <= 1'b0;
      de_d1     <= 1'b0;
      valid_d1  <= 1'b0;
      first_d1  <= 1'b0;
      top_ok_d1 <= 1'b0;
      mid_ok_d1 <= 1'b0;
      data_d1   <= '0;
      lb1_q     <= '0;
      lb2_q     <= '0;
      col_d1    <= '0;
    end else begin
      hs_d1     <= gray_hsync;
      vs_d1     <= gray_vsync;
      de_d1     <= gray_de;
      valid_d1  <= pix_ok;
      first_d1  <= de_rise;
      top_ok_d1 <= (row_cnt == 2'd2);
      mid_ok_d1 <= (row_cnt != 2'd0);
      data_d1   <= gray_data;
      col_d1    <= col_cnt;
      if (pix_ok) begin
        lb1_q <= lb1[col_cnt];
        lb2_q <= lb2[col_cnt];
      end

      if (de_fall) begin
        col_cnt   <= '0;
        line_full <= 1'b0;
      end else if (pix_ok) begin
        if (col_cnt == COL_MAX) line_full <= 1'b1;
        else                    col_cnt   <= col_cnt + 1'b1;
      end

      // A vsync rise overrides a de fall in the same cycle.
      if (vs_rise)                          row_cnt <= '0;
      else if (de_fall && row_cnt != 2'd2) row_cnt <= row_cnt + 1'b1;
    end
  end

  // The line buffers are never cleared; the row masks hide stale contents.
  // LB2 is written one cycle after the read, using the registered LB1 value.
  // The same column is not read again until the next line.
  always_ff @(posedge clk) begin
    if (!rst && pix_ok)   lb1[col_cnt] <= gray_data;
    if (!rst && valid_d1) lb2[col_d1]  <= lb1_q;
  end

  always_comb begin
    top_cur  = top_ok_d1 ? lb2_q : '0;
    mid_cur  = mid_ok_d1 ? lb1_q : '0;
    // The first pixel of a line sees empty history; this provides column masking.
    top_prev = first_d1 ? '0 : sh_top;
    mid_prev = first_d1 ? '0 : sh_mid;
    bot_prev = first_d1 ? '0 : sh_bot;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      matrix_hsync <= 1'b0;
      matrix_vsync <= 1'b0;
      matrix_de    <= 1'b0;
      matrix_data  <= '0;
      sh_top       <= '0;
      sh_mid       <= '0;
      sh_bot       <= '0;
    end else begin
      matrix_hsync <= hs_d1;
      matrix_vsync <= vs_d1;
      matrix_de    <= valid_d1;
      if (valid_d1) begin
        matrix_data <= {top_prev, top_cur, mid_prev, mid_cur, bot_prev, data_d1};
        sh_top      <= {top_prev[DW-1:0], top_cur};
        sh_mid      <= {mid_prev[DW-1:0], mid_cur};
        sh_bot      <= {bot_prev[DW-1:0], data_d1};
      end
    end
  end

endmodule

// File: tb/tb_gray_matrix_3x3.sv
module tb_gray_matrix_3x3;

  localparam int W  = 4;
  localparam int DW = 8;

  logic        clk;
  logic        rst;
  logic        gray_hsync, gray_vsync, gray_de;
  logic [7:0]  gray_data;
  logic        matrix_hsync, matrix_vsync, matrix_de;
  logic [71:0] matrix_data;

  gray_matrix_3x3 #(.IMG_WIDTH(W), .DW(DW)) dut (
    .clk          (clk),
    .rst          (rst),
    .gray_hsync   (gray_hsync),
    .gray_vsync   (gray_vsync),
    .gray_data    (gray_data),
    .gray_de      (gray_de),
    .matrix_hsync (matrix_hsync),
    .matrix_vsync (matrix_vsync),
    .matrix_de    (matrix_de),
    .matrix_data  (matrix_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;
  int fail_cnt = 0;

  // Reference model. It keeps the previous line and the line before that per
  // column, the frame row count, and the taps seen so far on the current line.
  typedef struct {
    logic        hs;
    logic        vs;
    logic        de;
    logic [71:0] win;
  } exp_t;

  logic [7:0]  m_lb1 [W];
  logic [7:0]  m_lb2 [W];
  logic [7:0]  t_top [W];
  logic [7:0]  t_mid [W];
  logic [7:0]  t_bot [W];
  int          m_rows, m_col;
  logic        m_pde, m_pvs;
  logic [71:0] m_hold;
  exp_t        pend, outx;

  function automatic logic [7:0] tap(input int row, input int i);
    if (i < 0) return 8'h00;
    case (row)
      0:       return t_top[i];
      1:       return t_mid[i];
      default: return t_bot[i];
    endcase
  endfunction

  task automatic model_edge(input logic r, input logic hs, input logic vs,
                            input logic de, input logic [7:0] d);
    int c;
    if (r) begin
      outx   = '{1'b0, 1'b0, 1'b0, 72'h0};
      pend   = '{1'b0, 1'b0, 1'b0, 72'h0};
      m_hold = '0;
      m_rows = 0;
      m_col  = 0;
      m_pde  = 1'b0;
      m_pvs  = 1'b0;
    end else begin
      outx = pend;
      if (pend.de) m_hold = pend.win;
      outx.win = m_hold;

      pend = '{hs, vs, 1'b0, 72'h0};
      if (de && m_col < W) begin
        c = m_col;
        t_top[c] = (m_rows >= 2) ? m_lb2[c] : 8'h00;
        t_mid[c] = (m_rows >= 1) ? m_lb1[c] : 8'h00;
        t_bot[c] = d;
        m_lb2[c] = m_lb1[c];
        m_lb1[c] = d;
        pend.de  = 1'b1;
        pend.win = {tap(0, c-2), tap(0, c-1), tap(0, c),
                    tap(1, c-2), tap(1, c-1), tap(1, c),
                    tap(2, c-2), tap(2, c-1), tap(2, c)};
      end
      if (de && m_col < W) m_col++;
      if (!de && m_pde) begin
        m_col = 0;
        if (m_rows < 2) m_rows++;
      end
      if (vs && !m_pvs) m_rows = 0;
      m_pde = de;
      m_pvs = vs;
    end
  endtask

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic hs, input logic vs,
                      input logic de, input logic [7:0] d);
    rst        = r;
    gray_hsync = hs;
    gray_vsync = vs;
    gray_de    = de;
    gray_data  = d;
    @(posedge clk);
    model_edge(r, hs, vs, de, d);
    #1;
    chk("hsync", 72'(matrix_hsync), 72'(outx.hs));
    chk("vsync", 72'(matrix_vsync), 72'(outx.vs));
    chk("de",    72'(matrix_de),    72'(outx.de));
    chk("data",  matrix_data,       outx.win);
  endtask

  logic [71:0] w;

  initial begin
    for (int i = 0; i < W; i++) begin
      m_lb1[i] = '0; m_lb2[i] = '0;
      t_top[i] = '0; t_mid[i] = '0; t_bot[i] = '0;
    end
    m_rows = 0; m_col = 0; m_pde = 0; m_pvs = 0; m_hold = '0;
    pend = '{1'b0, 1'b0, 1'b0, 72'h0};
    outx = pend;
    rst = 1; gray_hsync = 0; gray_vsync = 0; gray_de = 0; gray_data = 0;

    step(1, 0, 0, 0, 8'h00);
    step(1, 0, 0, 0, 8'h00);
    chk("reset_de", 72'(matrix_de), 72'h0);
    chk("reset_data", matrix_data, 72'h0);
    step(0, 0, 0, 0, 8'h00);

    // Frame 1: 4x4, where pixel (r,c) = 16r+c+1.
    step(0, 0, 1, 0, 8'h00);
    step(0, 0, 0, 0, 8'h00);
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        step(0, 0, 0, 1, 8'(16*r + c + 1));
        if (r == 0 && c == 1) begin
          w = {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01};
          chk("f1_p00", matrix_data, w);
          chk("f1_p00_de", 72'(matrix_de), 72'h1);
        end
        if (r == 1 && c == 1) begin
          w = {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h11};
          chk("f1_p10", matrix_data, w);
        end
        if (r == 2 && c == 3) begin
          w = {8'h01, 8'h02, 8'h03, 8'h11, 8'h12, 8'h13, 8'h21, 8'h22, 8'h23};
          chk("f1_p22", matrix_data, w);
        end
      end
      step(0, 1, 0, 0, 8'h00);
      step(0, 0, 0, 0, 8'h00);
    end

    // Frame 2: check that no stale rows appear, and drive an overlong first line.
    step(0, 0, 1, 0, 8'h00);
    step(0, 0, 0, 0, 8'h00);
    for (int c = 0; c < 6; c++) begin
      step(0, 0, 0, 1, 8'(c + 1));
      if (c == 2) begin
        w = {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h02};
        chk("f2_p01", matrix_data, w);
      end
      if (c == 4) chk("long_last_de", 72'(matrix_de), 72'h1);
      if (c == 5) chk("long_extra_de", 72'(matrix_de), 72'h0);
    end
    step(0, 1, 0, 0, 8'h00);
    chk("long_extra2_de", 72'(matrix_de), 72'h0);
    step(0, 0, 0, 0, 8'h00);
    for (int c = 0; c < 4; c++) step(0, 0, 0, 1, 8'(8'h11 + c));
    step(0, 1, 0, 0, 8'h00);
    w = {8'h00, 8'h00, 8'h00, 8'h02, 8'h03, 8'h04, 8'h12, 8'h13, 8'h14};
    chk("after_long_p13", matrix_data, w);
    step(0, 0, 0, 0, 8'h00);

    // Frame 3: reset during row 2.
    step(0, 0, 1, 0, 8'h00);
    step(0, 0, 0, 0, 8'h00);
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 4; c++) step(0, 0, 0, 1, 8'(8'h80 + 16*r + c));
      step(0, 1, 0, 0, 8'h00);
      step(0, 0, 0, 0, 8'h00);
    end
    step(0, 1, 0, 1, 8'hA0);
    step(0, 1, 0, 1, 8'hA1);
    step(1, 1, 1, 0, 8'h00);
    chk("rst_mid_de", 72'(matrix_de), 72'h0);
    chk("rst_mid_hs", 72'(matrix_hsync), 72'h0);
    chk("rst_mid_data", matrix_data, 72'h0);
    step(0, 0, 0, 0, 8'h00);
    step(0, 0, 0, 0, 8'h00);
    for (int c = 0; c < 4; c++) step(0, 0, 0, 1, 8'(8'hB0 + c));
    step(0, 1, 0, 0, 8'h00);
    w = {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hB1, 8'hB2, 8'hB3};
    chk("post_rst_p03", matrix_data, w);
    step(0, 0, 0, 0, 8'h00);

    // Random strobes and data.
    for (int i = 0; i < 800; i++) begin
      step(0, 1'($urandom_range(0, 1)), ($urandom_range(0, 59) == 0),
           ($urandom_range(0, 4) != 0), 8'($urandom));
    end
    step(0, 0, 0, 0, 8'h00);
    step(0, 0, 0, 0, 8'h00);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
